// File: rtl/frame_buffer_if.sv
// Sample stream and read port of the frame buffer.
// master = upstream source / reader, slave = frame_buffer.
interface frame_buffer_if #(
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned MAX_LOG_LENGTH   = 10
);
    logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata;
    logic                        S_AXIS_tvalid;
    logic                        S_AXIS_tready;
    logic                        rd_en;
    logic [MAX_LOG_LENGTH-1:0]   rd_addr;
    logic [AXIS_TDATA_WIDTH-1:0] rd_data;
    logic                        rd_valid;

    modport master (
        output S_AXIS_tdata, S_AXIS_tvalid, rd_en, rd_addr,
        input  S_AXIS_tready, rd_data, rd_valid
    );

    modport slave (
        input  S_AXIS_tdata, S_AXIS_tvalid, rd_en, rd_addr,
        output S_AXIS_tready, rd_data, rd_valid
    );
endinterface

// File: rtl/frame_buffer.sv
// Triggered single-frame capture of a sample stream into a block RAM,
// with a latency-1 read port usable in every state.
module frame_buffer #(
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned MAX_LOG_LENGTH   = 10
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [4:0]              FB_log_length,
    input  logic                    FB_start,
    input  logic                    FB_trigger,
    frame_buffer_if.slave           bus,
    output logic [1:0]              FB_state,
    output logic [MAX_LOG_LENGTH:0] FB_count
);
    localparam int unsigned DW    = AXIS_TDATA_WIDTH;
    localparam int unsigned AW    = MAX_LOG_LENGTH;
    localparam int unsigned CW    = MAX_LOG_LENGTH + 1;
    localparam int unsigned DEPTH = 1 << MAX_LOG_LENGTH;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_FILLING = 2'd2,
        S_FULL    = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_len;
    logic          r_trig_d;
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rd_data;
    logic          r_rd_valid;

    logic [4:0]    w_log_clamp;
    logic [CW-1:0] w_len;
    logic [CW-1:0] w_count_nxt;
    logic          w_edge;
    logic          w_we;

    assign w_log_clamp = (FB_log_length > 5'(MAX_LOG_LENGTH)) ? 5'(MAX_LOG_LENGTH) : FB_log_length;
    assign w_len       = CW'(1) << w_log_clamp;
    assign w_count_nxt = r_count + CW'(1);
    assign w_edge      = FB_trigger & ~r_trig_d;
    // A restart wins over a pending write, so the aborted beat is never stored.
    assign w_we        = (r_state == S_FILLING) & bus.S_AXIS_tvalid & ~FB_start;

    // Capture control: arm, wait for trigger edge, fill, hold until re-armed.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_len    <= CW'(1);
            r_trig_d <= 1'b1;
        end else begin
            r_trig_d <= FB_trigger;
            if (FB_start) begin
                r_state <= S_ARMED;
                r_count <= '0;
                r_len   <= w_len;
            end else begin
                case (r_state)
                    S_ARMED: begin
                        if (w_edge) r_state <= S_FILLING;
                    end
                    S_FILLING: begin
                        if (w_we) begin
                            r_count <= w_count_nxt;
                            if (w_count_nxt == r_len) r_state <= S_FULL;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Write port; contents deliberately survive reset and re-arm.
    always_ff @(posedge aclk) begin
        if (w_we) r_mem[r_count[AW-1:0]] <= bus.S_AXIS_tdata;
    end

    // Registered read port; same-cycle write to the same address reads old data.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= bus.rd_en;
            if (bus.rd_en) r_rd_data <= r_mem[bus.rd_addr];
        end
    end

    assign bus.S_AXIS_tready = 1'b1;
    assign bus.rd_data       = r_rd_data;
    assign bus.rd_valid      = r_rd_valid;
    assign FB_state          = r_state;
    assign FB_count          = r_count;
endmodule

// File: tb/tb_frame_buffer.sv
// Directed bench for frame_buffer: reset, basic frame, gaps, clamp,
// restart/priority, reset mid-fill and read-during-write.
module tb_frame_buffer;
    localparam int unsigned DW = 32;
    localparam int unsigned ML = 10;

    logic          aclk = 1'b0;
    logic          areset;
    logic [4:0]    FB_log_length;
    logic          FB_start;
    logic          FB_trigger;
    logic [1:0]    FB_state;
    logic [ML:0]   FB_count;

    int n_vec = 0;
    int n_err = 0;
    int k     = 0;
    int fk    = 0;
    int fk2   = 0;

    frame_buffer_if #(.AXIS_TDATA_WIDTH(DW), .MAX_LOG_LENGTH(ML)) fb_if ();

    frame_buffer #(.AXIS_TDATA_WIDTH(DW), .MAX_LOG_LENGTH(ML)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .FB_log_length (FB_log_length),
        .FB_start      (FB_start),
        .FB_trigger    (FB_trigger),
        .bus           (fb_if),
        .FB_state      (FB_state),
        .FB_count      (FB_count)
    );

    always #5 aclk = ~aclk;

    function automatic logic [31:0] mk(input int b);
        return {16'(b + 1), 16'(b)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: present beat k, pass the edge, sample 1 ns later.
    task automatic cyc();
        fb_if.S_AXIS_tdata = mk(k);
        @(posedge aclk);
        #1;
        k++;
    endtask

    task automatic arm(input logic [4:0] lg);
        FB_log_length = lg;
        FB_start = 1'b1;
        cyc();
        FB_start = 1'b0;
    endtask

    initial begin
        areset = 1'b1;
        FB_log_length = 5'd0;
        FB_start = 1'b0;
        FB_trigger = 1'b0;
        fb_if.S_AXIS_tvalid = 1'b0;
        fb_if.S_AXIS_tdata = '0;
        fb_if.rd_en = 1'b0;
        fb_if.rd_addr = '0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_state", 64'(FB_state), 64'd0);
        chk("rst_count", 64'(FB_count), 64'd0);
        chk("rst_rd_valid", 64'(fb_if.rd_valid), 64'd0);
        chk("rst_rd_data", 64'(fb_if.rd_data), 64'd0);
        chk("rst_tready", 64'(fb_if.S_AXIS_tready), 64'd1);
        areset = 1'b0;

        // Basic frame: L=4, trigger edge at beat 5, beats 6..9 stored
        k = 0;
        fb_if.S_AXIS_tvalid = 1'b1;
        arm(5'd2);
        chk("basic_armed", 64'(FB_state), 64'd1);
        while (k < 5) cyc();
        chk("basic_still_armed", 64'(FB_state), 64'd1);
        FB_trigger = 1'b1;
        cyc();
        chk("basic_filling", 64'(FB_state), 64'd2);
        chk("basic_edge_no_write", 64'(FB_count), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("basic_count", 64'(FB_count), 64'(i));
            chk("basic_state", 64'(FB_state), (i == 4) ? 64'd3 : 64'd2);
        end
        cyc();
        cyc();
        chk("basic_hold_count", 64'(FB_count), 64'd4);
        chk("basic_hold_full", 64'(FB_state), 64'd3);
        fb_if.rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fb_if.rd_addr = ML'(i);
            cyc();
            chk("basic_rd_valid", 64'(fb_if.rd_valid), 64'd1);
            chk("basic_rd_data", 64'(fb_if.rd_data), 64'(mk(6 + i)));
        end
        fb_if.rd_en = 1'b0;
        cyc();
        chk("basic_rd_idle", 64'(fb_if.rd_valid), 64'd0);

        // Gaps: tvalid 1,0,1,0 ... only valid beats stored
        arm(5'd2);
        chk("gap_armed", 64'(FB_state), 64'd1);
        FB_trigger = 1'b0;
        cyc();
        FB_trigger = 1'b1;
        cyc();
        chk("gap_filling", 64'(FB_state), 64'd2);
        fk = k;
        for (int i = 0; i < 8; i++) begin
            fb_if.S_AXIS_tvalid = ((i % 2) == 0);
            cyc();
            if (i == 5) begin
                chk("gap_count3", 64'(FB_count), 64'd3);
                chk("gap_state3", 64'(FB_state), 64'd2);
            end
            if (i == 6) begin
                chk("gap_count4", 64'(FB_count), 64'd4);
                chk("gap_full", 64'(FB_state), 64'd3);
            end
        end
        fb_if.S_AXIS_tvalid = 1'b1;
        fb_if.rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fb_if.rd_addr = ML'(i);
            cyc();
            chk("gap_rd_data", 64'(fb_if.rd_data), 64'(mk(fk + 2 * i)));
        end
        fb_if.rd_en = 1'b0;

        // Clamp: log length 15 -> 1024 words
        arm(5'd15);
        FB_trigger = 1'b0;
        cyc();
        FB_trigger = 1'b1;
        cyc();
        fk = k;
        repeat (1023) cyc();
        chk("clamp_count1023", 64'(FB_count), 64'd1023);
        chk("clamp_filling", 64'(FB_state), 64'd2);
        cyc();
        chk("clamp_count1024", 64'(FB_count), 64'd1024);
        chk("clamp_full", 64'(FB_state), 64'd3);
        fb_if.rd_en = 1'b1;
        fb_if.rd_addr = ML'(1023);
        cyc();
        chk("clamp_rd_last", 64'(fb_if.rd_data), 64'(mk(fk + 1023)));
        fb_if.rd_addr = ML'(4);
        cyc();
        chk("clamp_rd_4", 64'(fb_if.rd_data), 64'(mk(fk + 4)));
        fb_if.rd_en = 1'b0;

        // Restart at count 2
        arm(5'd2);
        FB_trigger = 1'b0;
        cyc();
        FB_trigger = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("rs_count2", 64'(FB_count), 64'd2);
        arm(5'd2);
        chk("rs_armed", 64'(FB_state), 64'd1);
        chk("rs_cleared", 64'(FB_count), 64'd0);

        // Start and trigger edge in the same cycle: start wins
        FB_trigger = 1'b0;
        cyc();
        FB_trigger = 1'b1;
        arm(5'd2);
        chk("prio_armed", 64'(FB_state), 64'd1);
        chk("prio_count", 64'(FB_count), 64'd0);
        cyc();
        chk("prio_level_armed", 64'(FB_state), 64'd1);
        chk("prio_no_write", 64'(FB_count), 64'd0);

        // Trigger held high: needs fall then rise; L stays latched at 4
        repeat (3) cyc();
        chk("held_armed", 64'(FB_state), 64'd1);
        FB_trigger = 1'b0;
        cyc();
        chk("held_low_armed", 64'(FB_state), 64'd1);
        FB_trigger = 1'b1;
        FB_log_length = 5'd0;
        cyc();
        chk("held_filling", 64'(FB_state), 64'd2);
        repeat (3) cyc();
        chk("latch_count3", 64'(FB_count), 64'd3);
        chk("latch_filling", 64'(FB_state), 64'd2);
        cyc();
        chk("latch_full", 64'(FB_state), 64'd3);
        chk("latch_count4", 64'(FB_count), 64'd4);

        // Reset mid-fill
        arm(5'd2);
        FB_trigger = 1'b0;
        cyc();
        FB_trigger = 1'b1;
        cyc();
        fk = k;
        repeat (3) cyc();
        chk("mid_count3", 64'(FB_count), 64'd3);
        areset = 1'b1;
        #1;
        chk("mid_async_state", 64'(FB_state), 64'd0);
        chk("mid_async_count", 64'(FB_count), 64'd0);
        chk("mid_async_rd_data", 64'(fb_if.rd_data), 64'd0);
        cyc();
        areset = 1'b0;
        chk("mid_idle", 64'(FB_state), 64'd0);
        arm(5'd2);
        FB_trigger = 1'b0;
        cyc();
        FB_trigger = 1'b1;
        cyc();
        fk2 = k;
        fb_if.rd_en = 1'b1;
        fb_if.rd_addr = ML'(0);
        cyc();
        chk("rdw_valid", 64'(fb_if.rd_valid), 64'd1);
        chk("rdw_old_data", 64'(fb_if.rd_data), 64'(mk(fk)));
        fb_if.rd_en = 1'b0;
        repeat (3) cyc();
        chk("refill_count", 64'(FB_count), 64'd4);
        chk("refill_full", 64'(FB_state), 64'd3);
        fb_if.rd_en = 1'b1;
        cyc();
        chk("refill_addr0", 64'(fb_if.rd_data), 64'(mk(fk2)));
        fb_if.rd_en = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/frame_buffer.md
FRAME_BUFFER -- requirements
Module: frame_buffer

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 32: stream word width, packed as two signed channels {ch_b[31:16], ch_a[15:0]}.
REQ-002 SHALL have parameter MAX_LOG_LENGTH, default 10: log2 of RAM depth (1024 words).
REQ-003 SHALL have one clock and an asynchronous active-high reset: ports aclk and areset.
REQ-004 aclk  in  1  sole clock; all logic on rising edge.
REQ-005 areset  in  1  asynchronous, active-high reset.
REQ-006 FB_log_length  in  5  log2 of the frame length; latched on start.
REQ-007 FB_start  in  1  single-cycle arm/restart pulse.
REQ-008 FB_trigger  in  1  trigger level; the frame begins on its rising edge.
REQ-009 S_AXIS_tdata  in  AXIS_TDATA_WIDTH  sample word from the upstream averager.
REQ-010 S_AXIS_tvalid  in  1  sample valid.
REQ-011 S_AXIS_tready  out  1  constant 1; the block never back-pressures.
REQ-012 FB_state  out  2  0=IDLE, 1=ARMED, 2=FILLING, 3=FULL.
REQ-013 FB_count  out  MAX_LOG_LENGTH+1  number of words written in the current frame.
REQ-014 rd_en  in  1  read request.
REQ-015 rd_addr  in  MAX_LOG_LENGTH  read word address.
REQ-016 rd_data  out  AXIS_TDATA_WIDTH  read data.
REQ-017 rd_valid  out  1  rd_data is valid.

Function
REQ-018 Frame length L SHALL be 2^min(FB_log_length, MAX_LOG_LENGTH), latched when FB_start is accepted; FB_log_length changes at other times SHALL be ignored.
REQ-019 The trigger edge SHALL be FB_trigger & ~trig_d, where trig_d is FB_trigger registered and reset to 1, so a trigger already high at reset or at arm needs a fresh rising edge.
REQ-020 The FSM SHALL behave as follows:
- IDLE --FB_start--> ARMED.
- ARMED --edge--> FILLING.
- FILLING --last write--> FULL.
- FULL --FB_start--> ARMED.
REQ-021 FB_start in ARMED, FILLING or FULL SHALL go to ARMED and clear FB_count to 0 on the next edge; FB_start SHALL take priority over a same-cycle trigger edge or last write.
REQ-022 Trigger edges outside ARMED SHALL be ignored.
REQ-023 In FILLING, each beat with S_AXIS_tvalid=1 SHALL write tdata to RAM[FB_count] and increment FB_count; cycles without tvalid SHALL write nothing.
REQ-024 The first stored word SHALL be the first valid beat in the cycle after the edge cycle; a beat in the edge cycle itself SHALL be discarded.
REQ-025 When a write makes FB_count equal L, the state SHALL be FULL from the next cycle; FB_count SHALL hold at L until the next accepted FB_start.
REQ-026 Beats in IDLE, ARMED and FULL SHALL be accepted (tready=1) and discarded.
REQ-027 Reads SHALL have fixed latency 1: rd_en at cycle n gives rd_data=RAM[rd_addr] with rd_valid=1 at n+1; rd_valid SHALL be 0 otherwise.
REQ-028 Reads SHALL be allowed in every state; a read of the address being written in the same cycle SHALL return the old content.
REQ-029 RAM contents SHALL be unaffected by reset and by re-arm; only FB_count defines valid data.
REQ-030 RAM SHALL be a simple dual-port inferred block RAM: one write port, one registered read port.

Reset
REQ-031 areset SHALL asynchronously force:
- FB_state=IDLE, FB_count=0;
- rd_valid=0, rd_data=0;
- trig_d=1, latched L=1.
REQ-032 S_AXIS_tready SHALL be 1 in and after reset.
REQ-033 areset asserted mid-fill SHALL abort the frame immediately; no write SHALL occur in the cycle reset is asserted.

Verification
REQ-034 Reset: assert areset for 3 cycles -> FB_state=0, FB_count=0, rd_valid=0, S_AXIS_tready=1.
REQ-035 Basic frame: FB_log_length=2, continuous tvalid, tdata={k+1,k}, FB_start, then trigger edge at beat k=5 -> FB_count=4 and FB_state=3 one cycle after the 4th write; reads of addr 0..3 return beats k=6..9 with 1-cycle latency.
REQ-036 Gaps: tvalid toggling 1,0,1,0 during FILLING with L=4 -> only valid beats stored; FULL after 4 valid beats (8 cycles).
REQ-037 Clamp: FB_log_length=15 -> exactly 1024 writes before FULL; FB_count=1024.
REQ-038 Restart and priority:
- FB_start at FB_count=2 -> ARMED, FB_count=0.
- FB_start and trigger edge in the same cycle -> ARMED, no write.
- Trigger held high through arm -> stays ARMED until the level falls and rises again.
REQ-039 Reset mid-fill: areset at FB_count=3 -> FB_state=0 and FB_count=0 asynchronously; a following FB_start plus edge refills from address 0.
